// File: rtl/reg_cmd_parser.sv
// Purpose: decode {rw,addr} command frames from a UART byte stream into register bank accesses.
// Latency: write DATA byte -> reg_wr next cycle -> ACK on tx two cycles after DATA; read CMD -> tx two cycles later.
// Backpressure: response held in RESP until tx_ready; rx bytes arriving while busy past GET_DATA are dropped.
module reg_cmd_parser #(
    parameter int          TIMEOUT_CYCLES = 1000,
    parameter logic [7:0]  ACK_BYTE       = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [6:0]  reg_addr,
    output logic [7:0]  reg_wdata,
    output logic        reg_wr,
    output logic        reg_wstrobe,
    input  logic [7:0]  reg_rdata,
    input  logic        reg_rvalid,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic        err_timeout,
    output logic        err_overrun
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    // The last GET_DATA cycle in which a DATA byte is still accepted.
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        GET_DATA = 3'd1,
        WRITE    = 3'd2,
        READ     = 3'd3,
        RESP     = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [6:0]      reg_addr_q, reg_addr_d;
    logic [7:0]      reg_wdata_q, reg_wdata_d;
    logic            reg_wr_q, reg_wr_d;
    logic            reg_wstrobe_q, reg_wstrobe_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic            tx_valid_q, tx_valid_d;
    logic            err_timeout_q, err_timeout_d;
    logic            err_overrun_q, err_overrun_d;

    // State and registered outputs; reset aborts any frame in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            reg_addr_q    <= '0;
            reg_wdata_q   <= '0;
            reg_wr_q      <= 1'b0;
            reg_wstrobe_q <= 1'b0;
            tx_data_q     <= '0;
            tx_valid_q    <= 1'b0;
            err_timeout_q <= 1'b0;
            err_overrun_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            reg_addr_q    <= reg_addr_d;
            reg_wdata_q   <= reg_wdata_d;
            reg_wr_q      <= reg_wr_d;
            reg_wstrobe_q <= reg_wstrobe_d;
            tx_data_q     <= tx_data_d;
            tx_valid_q    <= tx_valid_d;
            err_timeout_q <= err_timeout_d;
            err_overrun_q <= err_overrun_d;
        end
    end

    // Frame sequencing: next state and next values of every registered output.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        reg_addr_d    = reg_addr_q;
        reg_wdata_d   = reg_wdata_q;
        reg_wr_d      = 1'b0;
        reg_wstrobe_d = 1'b0;
        tx_data_d     = tx_data_q;
        tx_valid_d    = tx_valid_q;
        err_timeout_d = 1'b0;
        err_overrun_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (rx_valid) begin
                    reg_addr_d = rx_data[6:0];
                    if (rx_data[7]) begin
                        state_d = GET_DATA;
                        cnt_d   = '0;
                    end else begin
                        state_d = READ;
                    end
                end
            end
            GET_DATA: begin
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CW'(1);
                end
                // A byte landing in the expiry cycle still completes the frame.
                if (rx_valid) begin
                    reg_wdata_d   = rx_data;
                    reg_wr_d      = 1'b1;
                    reg_wstrobe_d = 1'b1;
                    state_d       = WRITE;
                end else if (cnt_q >= CNT_LAST) begin
                    err_timeout_d = 1'b1;
                    state_d       = IDLE;
                end
            end
            WRITE: begin
                tx_data_d  = ACK_BYTE;
                tx_valid_d = 1'b1;
                state_d    = RESP;
            end
            READ: begin
                if (reg_rvalid) begin
                    tx_data_d  = reg_rdata;
                    tx_valid_d = 1'b1;
                    state_d    = RESP;
                end
            end
            RESP: begin
                if (tx_ready) begin
                    tx_valid_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Bytes that arrive while an access or response is pending are lost.
        if (rx_valid && (state_q == WRITE || state_q == READ || state_q == RESP)) begin
            err_overrun_d = 1'b1;
        end
    end

    assign reg_addr    = reg_addr_q;
    assign reg_wdata   = reg_wdata_q;
    assign reg_wr      = reg_wr_q;
    assign reg_wstrobe = reg_wstrobe_q;
    assign tx_data     = tx_data_q;
    assign tx_valid    = tx_valid_q;
    assign busy        = (state_q != IDLE);
    assign err_timeout = err_timeout_q;
    assign err_overrun = err_overrun_q;

endmodule

// File: tb/tb_reg_cmd_parser.sv
// Purpose: directed bench for reg_cmd_parser with a register bank model and write/response scoreboards.
// Latency: inputs driven 1 time unit after the rising edge, outputs sampled on the falling edge.
// Backpressure: tx_ready is held low for a stretch to exercise the RESP hold.
module tb_reg_cmd_parser;

    localparam int T = 1000;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [6:0]  reg_addr;
    logic [7:0]  reg_wdata;
    logic        reg_wr;
    logic        reg_wstrobe;
    logic [7:0]  reg_rdata;
    logic        reg_rvalid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy;
    logic        err_timeout;
    logic        err_overrun;

    logic        bank_init = 1'b0;
    logic [7:0]  mem [128];

    int          n_vec = 0;
    int          n_err = 0;
    logic [7:0]  exp_tx [$];
    logic [14:0] exp_wr [$];
    logic [7:0]  e_tx;
    logic [14:0] e_wr;
    int          cyc;

    reg_cmd_parser #(.TIMEOUT_CYCLES(T), .ACK_BYTE(8'hA5)) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .reg_addr    (reg_addr),
        .reg_wdata   (reg_wdata),
        .reg_wr      (reg_wr),
        .reg_wstrobe (reg_wstrobe),
        .reg_rdata   (reg_rdata),
        .reg_rvalid  (reg_rvalid),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .busy        (busy),
        .err_timeout (err_timeout),
        .err_overrun (err_overrun)
    );

    always #5 clk = ~clk;

    // Register bank model: preset contents addr ^ 8'h5A, written on the strobe.
    always @(posedge clk or posedge bank_init) begin
        if (bank_init) begin
            for (int i = 0; i < 128; i++) mem[i] <= 8'(i) ^ 8'h5A;
        end else if (reg_wr && reg_wstrobe) begin
            mem[reg_addr] <= reg_wdata;
        end
    end
    assign reg_rdata  = mem[reg_addr];
    assign reg_rvalid = ~reg_wr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk);
        #1;
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    // Every bank write must match the next expected {addr,data}; an extra cycle of reg_wr finds none.
    always @(negedge clk) begin
        if (!rst && (reg_wr || reg_wstrobe)) begin
            n_vec++;
            if (exp_wr.size() == 0) begin
                n_err++;
                $error("FAIL unexpected_write: observed addr %0h data %0h expected none", reg_addr, reg_wdata);
            end else begin
                e_wr = exp_wr.pop_front();
                assert ({reg_wr, reg_wstrobe, reg_addr, reg_wdata} === {2'b11, e_wr}) else begin
                    n_err++;
                    $error("FAIL bank_write: observed %0h expected %0h",
                           {reg_wr, reg_wstrobe, reg_addr, reg_wdata}, {2'b11, e_wr});
                end
            end
        end
    end

    // Every tx handshake must carry the next expected response byte.
    always @(negedge clk) begin
        if (!rst && tx_valid && tx_ready) begin
            n_vec++;
            if (exp_tx.size() == 0) begin
                n_err++;
                $error("FAIL unexpected_tx: observed %0h expected none", tx_data);
            end else begin
                e_tx = exp_tx.pop_front();
                assert (tx_data === e_tx) else begin
                    n_err++;
                    $error("FAIL tx_byte: observed %0h expected %0h", tx_data, e_tx);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        tx_ready = 1'b1;
        #1 bank_init = 1'b1;
        #1 bank_init = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", 32'({reg_addr, reg_wdata, reg_wr, reg_wstrobe, tx_data, tx_valid,
                                  busy, err_timeout, err_overrun}), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_after_reset", 32'(busy), 32'd0);

        // 1: write 0x3C to address 5
        exp_wr.push_back({7'h05, 8'h3C});
        exp_tx.push_back(8'hA5);
        send_byte(8'h85);
        @(negedge clk);
        chk("t1_getdata", 32'({busy, reg_wr, reg_addr}), 32'({1'b1, 1'b0, 7'h05}));
        send_byte(8'h3C);
        @(negedge clk);
        chk("t1_wr_pulse", 32'({reg_wr, reg_wstrobe, reg_addr, reg_wdata, tx_valid}),
            32'({1'b1, 1'b1, 7'h05, 8'h3C, 1'b0}));
        @(negedge clk);
        chk("t1_ack", 32'({reg_wr, reg_wstrobe, tx_valid, tx_data}), 32'({3'b001, 8'hA5}));

        // 2: read back address 5
        exp_tx.push_back(8'h3C);
        send_byte(8'h05);
        @(negedge clk);
        chk("t2_read_state", 32'({busy, reg_wr, tx_valid}), 32'(3'b100));
        @(negedge clk);
        chk("t2_read_data", 32'({tx_valid, tx_data}), 32'({1'b1, 8'h3C}));

        // 3: write CMD then silence until timeout, then a normal read of 0x7F
        send_byte(8'hFF);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!err_timeout && cyc < T + 20);
        chk("t3_timeout_latency", 32'(cyc), 32'(T + 1));
        chk("t3_idle", 32'({busy, reg_wr}), 32'd0);
        @(negedge clk);
        chk("t3_pulse_width", 32'(err_timeout), 32'd0);
        exp_tx.push_back(8'h25);
        send_byte(8'h7F);
        repeat (2) @(negedge clk);
        chk("t3_read_after", 32'({tx_valid, tx_data}), 32'({1'b1, 8'h25}));

        // 4: response held under backpressure, overrun byte dropped
        @(posedge clk);
        #1 tx_ready = 1'b0;
        exp_tx.push_back(8'h3C);
        send_byte(8'h05);
        repeat (2) @(negedge clk);
        chk("t4_resp", 32'({tx_valid, tx_data}), 32'({1'b1, 8'h3C}));
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            rx_data  = 8'h81;
            rx_valid = (i == 3);
            @(negedge clk);
            chk($sformatf("t4_hold_%0d", i), 32'({tx_valid, tx_data, err_overrun, busy}),
                32'({1'b1, 8'h3C, (i == 4), 1'b1}));
        end
        chk("t4_addr_kept", 32'(reg_addr), 32'h05);
        @(posedge clk);
        #1 tx_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("t4_idle", 32'({busy, tx_valid}), 32'd0);

        // 5: reset in GET_DATA aborts the frame; next write completes
        send_byte(8'h90);
        @(negedge clk);
        chk("t5_in_getdata", 32'({busy, reg_addr}), 32'({1'b1, 7'h10}));
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("t5_reset_outputs", 32'({reg_addr, reg_wdata, reg_wr, reg_wstrobe, tx_data, tx_valid,
                                     busy, err_timeout, err_overrun}), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        exp_wr.push_back({7'h01, 8'h11});
        exp_tx.push_back(8'hA5);
        send_byte(8'h81);
        send_byte(8'h11);
        @(negedge clk);
        chk("t5_wr", 32'({reg_wr, reg_addr, reg_wdata}), 32'({1'b1, 7'h01, 8'h11}));
        @(negedge clk);
        chk("t5_ack", 32'({tx_valid, tx_data}), 32'({1'b1, 8'hA5}));

        // 6: DATA byte exactly in the expiry cycle is accepted
        exp_wr.push_back({7'h22, 8'hC3});
        exp_tx.push_back(8'hA5);
        send_byte(8'hA2);
        repeat (T - 2) @(posedge clk);
        send_byte(8'hC3);
        @(negedge clk);
        chk("t6_expiry_accept", 32'({reg_wr, reg_addr, reg_wdata, err_timeout}),
            32'({1'b1, 7'h22, 8'hC3, 1'b0}));
        @(negedge clk);
        chk("t6_ack", 32'({tx_valid, tx_data, err_timeout}), 32'({1'b1, 8'hA5, 1'b0}));

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 32'(exp_tx.size() + exp_wr.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
